// File: rtl/div_unit.sv
// Iterative restoring radix-2 integer divider for RV64M DIV/DIVU/REM/REMU and W forms.
// Ports: clk, rstn, flush, in_valid/in_ready + dividend/divisor/div_op/is_word, out_valid/out_ready + result.
module div_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic [1:0]      div_op,
  input  logic            is_word,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int H = XLEN / 2;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t          state;
  logic [6:0]      cnt;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] dv;
  logic            word_q;
  logic            rem_sel;
  logic            neg_q;
  logic            neg_r;

  function automatic logic [XLEN-1:0] wsext(
    input logic [XLEN-1:0] x,
    input logic            w
  );
    return w ? {{H{x[H-1]}}, x[H-1:0]} : x;
  endfunction

  logic            op_signed;
  logic            op_rem;
  logic [XLEN-1:0] eff_a;
  logic [XLEN-1:0] eff_b;
  logic            sa;
  logic            sb;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic [XLEN-1:0] min_val;
  logic            div0;
  logic            ovf;
  logic [XLEN-1:0] sp_res;
  logic [XLEN-1:0] load_q;

  always_comb begin
    op_signed = ~div_op[0];
    op_rem    = div_op[1];
    if (is_word) begin
      eff_a = op_signed ? {{H{dividend[H-1]}}, dividend[H-1:0]}
                        : {{H{1'b0}}, dividend[H-1:0]};
      eff_b = op_signed ? {{H{divisor[H-1]}}, divisor[H-1:0]}
                        : {{H{1'b0}}, divisor[H-1:0]};
    end else begin
      eff_a = dividend;
      eff_b = divisor;
    end
    sa      = op_signed & eff_a[XLEN-1];
    sb      = op_signed & eff_b[XLEN-1];
    mag_a   = sa ? -eff_a : eff_a;
    mag_b   = sb ? -eff_b : eff_b;
    min_val = is_word ? {{(H+1){1'b1}}, {(H-1){1'b0}}}
                      : {1'b1, {(XLEN-1){1'b0}}};
    div0    = (eff_b == '0);
    ovf     = op_signed & (eff_a == min_val) & (&eff_b);
    if (div0)
      sp_res = op_rem ? eff_a : '1;
    else
      sp_res = op_rem ? '0 : eff_a;
    sp_res  = wsext(sp_res, is_word);
    // W forms park the 32-bit magnitude in the top half so the
    // same left-shifting datapath yields the quotient in the low half.
    load_q  = is_word ? {mag_a[H-1:0], {H{1'b0}}} : mag_a;
  end

  logic [XLEN:0]   trial;
  logic            ge;
  logic [XLEN-1:0] nr;
  logic [XLEN-1:0] nq;
  logic [XLEN-1:0] fq;
  logic [XLEN-1:0] fr;
  logic [XLEN-1:0] fin_res;
  logic            last;

  always_comb begin
    trial   = {rem, quo[XLEN-1]};
    ge      = (trial >= {1'b0, dv});
    // When ge holds the difference is below dv, so 64 bits suffice.
    nr      = ge ? (trial[XLEN-1:0] - dv) : trial[XLEN-1:0];
    nq      = {quo[XLEN-2:0], ge};
    fq      = neg_q ? -nq : nq;
    fr      = neg_r ? -nr : nr;
    fin_res = wsext(rem_sel ? fr : fq, word_q);
    last    = (cnt == (word_q ? 7'd31 : 7'd63));
  end

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      cnt       <= '0;
      rem       <= '0;
      quo       <= '0;
      dv        <= '0;
      word_q    <= 1'b0;
      rem_sel   <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      cnt       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            word_q  <= is_word;
            rem_sel <= op_rem;
            neg_q   <= sa ^ sb;
            neg_r   <= sa;
            cnt     <= '0;
            rem     <= '0;
            quo     <= load_q;
            dv      <= mag_b;
            if (div0 || ovf) begin
              state     <= DONE;
              out_valid <= 1'b1;
              result    <= sp_res;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem <= nr;
          quo <= nq;
          cnt <= cnt + 7'd1;
          if (last) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= fin_res;
            cnt       <= '0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vectors, reference model, latency,
// stall, flush and reset-abort checks.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic [1:0]  div_op;
  logic        is_word;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc = 0;

  logic [63:0] exp_q[$];
  int          lat_q[$];

  div_unit #(.XLEN(64)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .div_op(div_op), .is_word(is_word),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rstn && !flush && in_valid && in_ready)
      acc <= cyc;
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [63:0] x);
    return {{32{x[31]}}, x[31:0]};
  endfunction

  function automatic bit is_special(input logic [63:0] a, input logic [63:0] b,
                                    input logic [1:0] op, input logic w);
    bit sg;
    logic [63:0] ea, eb;
    sg = (op == 2'd0) || (op == 2'd2);
    ea = w ? (sg ? sx32(a) : {32'b0, a[31:0]}) : a;
    eb = w ? (sg ? sx32(b) : {32'b0, b[31:0]}) : b;
    if (eb == 64'd0) return 1'b1;
    return sg && (eb == 64'hFFFF_FFFF_FFFF_FFFF) &&
           (ea == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
  endfunction

  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic [1:0] op, input logic w);
    bit sg, rm;
    logic [63:0] ea, eb, r;
    sg = (op == 2'd0) || (op == 2'd2);
    rm = op[1];
    ea = w ? (sg ? sx32(a) : {32'b0, a[31:0]}) : a;
    eb = w ? (sg ? sx32(b) : {32'b0, b[31:0]}) : b;
    if (eb == 64'd0)
      r = rm ? ea : 64'hFFFF_FFFF_FFFF_FFFF;
    else if (is_special(a, b, op, w))
      r = rm ? 64'd0 : ea;
    else if (sg)
      r = rm ? 64'($signed(ea) % $signed(eb)) : 64'($signed(ea) / $signed(eb));
    else
      r = rm ? ea % eb : ea / eb;
    return w ? sx32(r) : r;
  endfunction

  function automatic int model_lat(input logic [63:0] a, input logic [63:0] b,
                                   input logic [1:0] op, input logic w);
    if (is_special(a, b, op, w)) return 1;
    return w ? 33 : 65;
  endfunction

  bit          seen = 1'b0;
  logic [63:0] held;

  always @(negedge clk) begin
    logic [63:0] e;
    int          l;
    if (!out_valid) begin
      seen = 1'b0;
      chk("idle_result_zero", result, 64'd0);
    end else if (!seen) begin
      seen = 1'b1;
      held = result;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out_valid: got result %h want none", result);
      end else begin
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        chk("result", result, e);
        chk("latency", 64'(cyc - acc), 64'(l));
      end
    end else begin
      chk("stall_result_stable", result, held);
      chk("stall_in_ready_low", {63'd0, in_ready}, 64'd0);
    end
  end

  task automatic issue(input logic [63:0] a, input logic [63:0] b,
                       input logic [1:0] op, input logic w, input bit track);
    int n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("issue_ready", {63'd0, in_ready}, 64'd1);
    dividend = a;
    divisor  = b;
    div_op   = op;
    is_word  = w;
    in_valid = 1'b1;
    if (track) begin
      exp_q.push_back(model(a, b, op, w));
      lat_q.push_back(model_lat(a, b, op, w));
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    bit ok = 1'b0;
    while (n < 300 && !ok) begin
      @(negedge clk);
      n++;
      ok = (exp_q.size() == 0) && in_ready;
    end
    chk("done_in_time", {63'd0, ok}, 64'd1);
  endtask

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  op;
    logic        w;
    logic [63:0] hand;
    int          lat;
  } vec_t;

  vec_t v[16];

  initial begin
    v[0]  = '{64'd100, 64'd7, 2'd1, 1'b0, 64'd14, 65};
    v[1]  = '{64'd100, 64'd7, 2'd3, 1'b0, 64'd2, 65};
    v[2]  = '{-64'sd7, 64'd2, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    v[3]  = '{-64'sd7, 64'd2, 2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    v[4]  = '{64'd5, 64'd0, 2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    v[5]  = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'd2, 1'b0, 64'd0, 1};
    v[6]  = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 1'b0,
              64'h8000_0000_0000_0000, 1};
    v[7]  = '{64'h1_8000_0000, 64'hFFFF_FFFF, 2'd0, 1'b1, 64'hFFFF_FFFF_8000_0000, 1};
    v[8]  = '{64'hFFFF_FFFF, 64'd1, 2'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 33};
    v[9]  = '{64'd7, -64'sd2, 2'd2, 1'b0, 64'd1, 65};
    v[10] = '{64'd7, -64'sd2, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    v[11] = '{64'hFFFF_FFF9, 64'd2, 2'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 33};
    v[12] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 2'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 65};
    v[13] = '{64'd5, 64'd0, 2'd3, 1'b0, 64'd5, 1};
    v[14] = '{64'hDEAD_0000_0000_0010, 64'h1234_0000_0000_0003, 2'd1, 1'b1, 64'd5, 33};
    v[15] = '{64'h8000_0000, 64'd1, 2'd1, 1'b1, 64'hFFFF_FFFF_8000_0000, 33};

    rstn      = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    div_op    = '0;
    is_word   = 1'b0;
    #2;
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_result", result, 64'd0);
    #10 rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      chk($sformatf("model_pin_%0d", i), model(v[i].a, v[i].b, v[i].op, v[i].w), v[i].hand);
      chk($sformatf("lat_pin_%0d", i),
          64'(model_lat(v[i].a, v[i].b, v[i].op, v[i].w)), 64'(v[i].lat));
      issue(v[i].a, v[i].b, v[i].op, v[i].w, 1'b1);
      wait_done();
    end

    out_ready = 1'b0;
    issue(64'd100, 64'd7, 2'd1, 1'b0, 1'b1);
    begin
      int n = 0;
      while (!out_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    chk("stall_reached_done", {63'd0, out_valid}, 64'd1);
    repeat (10) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_out_valid", {63'd0, out_valid}, 64'd0);
    chk("release_in_ready", {63'd0, in_ready}, 64'd1);

    issue(64'd1000, 64'd3, 2'd1, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    repeat (80) @(negedge clk);

    issue(64'd999, 64'd4, 2'd3, 1'b0, 1'b0);
    repeat (30) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_result", result, 64'd0);
    #2 rstn = 1'b1;
    repeat (80) @(negedge clk);

    issue(64'd123456789, 64'd1000, 2'd3, 1'b0, 1'b1);
    wait_done();
    issue(-64'sd100, 64'd7, 2'd0, 1'b1, 1'b1);
    wait_done();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test want finish");
    $fatal(1);
  end

endmodule
